// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-panel logic.
package microwave_pkg;

  localparam int         NUM_DIGIT_KEYS = 10;
  localparam logic [3:0] BCD_BLANK      = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } kp_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous key lines; 2-cycle latency, no backpressure.
module key_sync #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Debounced digit-key to BCD encoder with single-press strobe and multi-key reject.
// Strobe appears DEBOUNCE_CYCLES+2 edges after a stable pattern first enters the synchronizer; no backpressure.
module keypad_bcd_encoder
  import microwave_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_DIGIT_KEYS-1:0] keys,
  output logic [3:0]                bcd,
  output logic                      bcd_valid,
  output logic                      multi_key,
  output logic                      key_held
);

  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGIT_KEYS-1:0] KEY_ONE  = NUM_DIGIT_KEYS'(1);

  logic [NUM_DIGIT_KEYS-1:0] ks;
  logic [NUM_DIGIT_KEYS-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  kp_state_e                 state_q, state_d;
  logic [3:0]                bcd_q, bcd_d;
  logic                      valid_q, valid_d;
  logic                      multi_q, multi_d;
  logic                      cnt_done;
  logic                      cap_onehot;
  logic [3:0]                cap_idx;

  key_sync #(.WIDTH(NUM_DIGIT_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (keys),
    .q_o   (ks)
  );

  assign cnt_done   = (cnt_q == CNT_LAST);
  // Clearing the lowest set bit leaves zero only for a single-bit pattern.
  assign cap_onehot = (cap_q != '0) && ((cap_q & (cap_q - KEY_ONE)) == '0);

  always_comb begin
    cap_idx = 4'd0;
    for (int i = 0; i < NUM_DIGIT_KEYS; i++) begin
      if (cap_q[i]) cap_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    multi_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ks != '0) begin
          cap_d   = ks;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (ks != cap_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_done) begin
          cnt_d   = '0;
          state_d = HELD;
          if (cap_onehot) begin
            bcd_d   = cap_idx;
            valid_d = 1'b1;
          end else begin
            multi_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        // Roll-over to other keys is ignored until the panel goes fully quiet.
        if (ks == '0) begin
          cnt_d   = '0;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (ks != '0) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= BCD_BLANK;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign multi_key = multi_q;
  assign key_held  = (state_q == HELD) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: reference model, directed segment table, corner sequences, random segments.
module tb_keypad_bcd_encoder;

  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] keys  = 10'h3FF;
  logic [3:0] bcd;
  logic       bcd_valid;
  logic       multi_key;
  logic       key_held;

  keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .multi_key (multi_key),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_multi  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the key pattern seen by the decision logic lags the pins by
  // two edges; a press is accepted once the same nonzero pattern has been seen on
  // D+1 consecutive edges, and a held press ends after D+1 consecutive all-zero edges.
  logic [9:0] m_s1 = '0, m_s2 = '0, m_ks, win_val = '0;
  int         win_len = 0, zeros = 0;
  bit         m_held = 0, m_valid = 0, m_multi = 0;
  logic [3:0] m_bcd = 4'hF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; win_val = '0; win_len = 0; zeros = 0;
      m_held = 0; m_valid = 0; m_multi = 0; m_bcd = 4'hF;
    end else begin
      m_ks = m_s2; m_s2 = m_s1; m_s1 = keys;
      m_valid = 0; m_multi = 0;
      if (!m_held) begin
        if (win_len == 0) begin
          if (m_ks != 0) begin win_val = m_ks; win_len = 1; end
        end else if (m_ks != win_val) begin
          win_len = 0;
        end else begin
          win_len++;
          if (win_len == D + 1) begin
            m_held = 1; win_len = 0; zeros = 0;
            if ($countones(win_val) == 1) begin
              m_valid = 1; m_bcd = 4'($clog2(win_val));
            end else begin
              m_multi = 1;
            end
          end
        end
      end else begin
        if (m_ks == 0) begin
          zeros++;
          if (zeros == D + 1) begin m_held = 0; zeros = 0; end
        end else begin
          zeros = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bcd_valid) n_valid++;
      if (multi_key) n_multi++;
      if (chk_en) begin
        check("model_bcd",       bcd,       m_bcd);
        check("model_bcd_valid", bcd_valid, m_valid);
        check("model_multi_key", multi_key, m_multi);
        check("model_key_held",  key_held,  m_held);
      end
    end
  end

  typedef struct {
    logic [9:0] k;
    int         cycles;
    int         exp_valid;
    int         exp_multi;
    int         exp_bcd;
    int         exp_held;
  } seg_t;

  seg_t tbl[$];

  task automatic drive(input logic [9:0] k, input int n);
    keys = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, m0, lat_v, lat_h;
    logic [9:0] rk;

    tbl.push_back(seg_t'{10'h020, 20, 1, 0, 5, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 5, 0});
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(seg_t'{10'h008, 2, 0, 0, 5, 0});
      tbl.push_back(seg_t'{10'h000, 2, 0, 0, 5, 0});
    end
    tbl.push_back(seg_t'{10'h008, 12, 1, 0, 3, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 3, 0});
    tbl.push_back(seg_t'{10'h084, 12, 0, 1, 3, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 3, 0});
    tbl.push_back(seg_t'{10'h002, 12, 1, 0, 1, 1});
    tbl.push_back(seg_t'{10'h202,  8, 0, 0, 1, 1});
    tbl.push_back(seg_t'{10'h200,  8, 0, 0, 1, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 1, 0});
    tbl.push_back(seg_t'{10'h200, 12, 1, 0, 9, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 9, 0});
    tbl.push_back(seg_t'{10'h010, 12, 1, 0, 4, 1});
    tbl.push_back(seg_t'{10'h000,  3, 0, 0, 4, 1});
    tbl.push_back(seg_t'{10'h010,  6, 0, 0, 4, 1});
    tbl.push_back(seg_t'{10'h000, 10, 0, 0, 4, 0});

    // Reset with every key pressed.
    repeat (3) @(negedge clk);
    check("rst_bcd",       bcd,       4'hF);
    check("rst_bcd_valid", bcd_valid, 0);
    check("rst_multi_key", multi_key, 0);
    check("rst_key_held",  key_held,  0);
    keys   = '0;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    v0 = n_valid; m0 = n_multi;
    drive(10'h000, 20);
    check("post_rst_bcd",     bcd,             4'hF);
    check("post_rst_held",    key_held,        0);
    check("post_rst_strobes", n_valid - v0 + n_multi - m0, 0);

    foreach (tbl[i]) begin
      v0 = n_valid; m0 = n_multi;
      drive(tbl[i].k, tbl[i].cycles);
      check($sformatf("seg%0d_valid_cnt", i), n_valid - v0, tbl[i].exp_valid);
      check($sformatf("seg%0d_multi_cnt", i), n_multi - m0, tbl[i].exp_multi);
      check($sformatf("seg%0d_bcd", i),       bcd,          tbl[i].exp_bcd);
      check($sformatf("seg%0d_held", i),      key_held,     tbl[i].exp_held);
    end

    // Exact press latency: edge 0 is the first edge that samples the new pattern.
    lat_v = -1; lat_h = -1;
    keys  = 10'h040;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #2;
      if (bcd_valid && lat_v < 0) lat_v = e;
      if (key_held && lat_h < 0) lat_h = e;
    end
    check("latency_valid", lat_v, D + 2);
    check("latency_held",  lat_h, D + 2);
    check("latency_bcd",   bcd,   6);
    @(negedge clk);
    drive(10'h000, 10);

    // Reset in the middle of a press debounce.
    v0 = n_valid; m0 = n_multi;
    keys = 10'h100;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_bcd",   bcd,       4'hF);
    check("midrst_valid", bcd_valid, 0);
    check("midrst_held",  key_held,  0);
    repeat (3) @(negedge clk);
    check("midrst_no_strobe", n_valid - v0 + n_multi - m0, 0);
    rst_n = 1'b1;
    v0 = n_valid;
    drive(10'h100, 12);
    check("midrst_resume_valid", n_valid - v0, 1);
    check("midrst_resume_bcd",   bcd,          8);
    check("midrst_resume_held",  key_held,     1);
    drive(10'h000, 10);

    // Random segments against the model.
    for (int s = 0; s < 200; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      rk = '0;
      else if (r < 8) rk = 10'(1) << $urandom_range(0, 9);
      else            rk = 10'($urandom_range(1, 1023));
      drive(rk, $urandom_range(1, 12));
    end
    drive(10'h000, 12);
    check("final_held", key_held, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
